// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle base integer ops plus iterative
// RV32M-style multiply (shift-add) and divide (restoring) on operand magnitudes.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             sign,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return {(2*WIDTH){1'b0}} - v;
  endfunction

  logic accept;
  assign accept = in_valid && in_ready;

  // Base ALU, evaluated directly on the presented operands
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          sum_ext, dif_ext;
  logic [SHW-1:0]          shamt;
  logic [WIDTH-1:0]        base_res;
  logic                    base_cout, base_ovf;

  assign a_s     = src1;
  assign b_s     = src2;
  assign sum_ext = {1'b0, src1} + {1'b0, src2};
  assign dif_ext = {1'b0, src1} - {1'b0, src2};
  assign shamt   = src2[SHW-1:0];

  always_comb begin
    base_res  = '0;
    base_cout = 1'b0;
    base_ovf  = 1'b0;
    case (op[3:0])
      4'd0: begin
        base_res  = sum_ext[WIDTH-1:0];
        base_cout = sum_ext[WIDTH];
        base_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum_ext[WIDTH-1] != src1[WIDTH-1]);
      end
      4'd1: begin
        base_res  = dif_ext[WIDTH-1:0];
        base_cout = dif_ext[WIDTH];
        base_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) && (dif_ext[WIDTH-1] != src1[WIDTH-1]);
      end
      4'd2: base_res = src1 & src2;
      4'd3: base_res = src1 | src2;
      4'd4: base_res = src1 ^ src2;
      4'd5: base_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'd6: base_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
      4'd7: base_res = src1 << shamt;
      4'd8: base_res = src1 >> shamt;
      4'd9: base_res = a_s >>> shamt;
      default: base_res = '0;
    endcase
  end

  // M-op setup: operand signedness, magnitudes and early-out detection
  logic [2:0]       f3;
  logic             is_m, is_div, sgn_a, sgn_b, neg_a, neg_b;
  logic             div_zero, div_ovf, early, res_neg_in;
  logic [WIDTH-1:0] mag_a, mag_b, early_res;

  assign f3         = op[2:0];
  assign is_m       = op[4];
  assign is_div     = f3[2];
  assign sgn_a      = is_div ? !f3[0] : (f3 != 3'd3);
  assign sgn_b      = is_div ? !f3[0] : !f3[1];
  assign neg_a      = sgn_a && src1[WIDTH-1];
  assign neg_b      = sgn_b && src2[WIDTH-1];
  assign mag_a      = neg_a ? neg_w(src1) : src1;
  assign mag_b      = neg_b ? neg_w(src2) : src2;
  assign div_zero   = (src2 == '0);
  assign div_ovf    = !f3[0] && (src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&src2);
  assign early      = is_div && (div_zero || div_ovf);
  assign early_res  = div_zero ? (f3[1] ? src1 : '1) : (f3[1] ? '0 : src1);
  assign res_neg_in = (is_div && f3[1]) ? neg_a : (neg_a ^ neg_b);

  // Iteration datapath: hi/lo hold product halves or remainder/quotient
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [2:0]       m_f3;
  logic             res_neg;
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]     mul_sum, r_sh;
  logic               ge;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt, div_v, div_s, m_res;
  logic [2*WIDTH-1:0] prod_s;

  assign mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {WIDTH{1'b0}})};
  assign r_sh    = {hi, lo[WIDTH-1]};
  assign ge      = (r_sh >= {1'b0, opnd});

  always_comb begin
    if (m_f3[2]) begin
      hi_nxt = ge ? (r_sh[WIDTH-1:0] - opnd) : r_sh[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ge};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  assign prod_s = res_neg ? neg_2w({hi_nxt, lo_nxt}) : {hi_nxt, lo_nxt};
  assign div_v  = m_f3[1] ? hi_nxt : lo_nxt;
  assign div_s  = res_neg ? neg_w(div_v) : div_v;
  assign m_res  = m_f3[2] ? div_s :
                  (m_f3 == 3'd0) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      hi      <= '0;
      lo      <= mag_a;
      opnd    <= mag_b;
      m_f3    <= f3;
      res_neg <= res_neg_in;
    end else if (state == BUSY) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

  // Control FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (!is_m || early) ? DONE : BUSY;
      BUSY: if (cnt == LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == BUSY);
  end

  // Result register: loaded on base/early-out accept or on the last iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      out      <= '0;
      zero     <= 1'b0;
      sign     <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept && !is_m) begin
            out      <= base_res;
            zero     <= (base_res == '0);
            sign     <= base_res[WIDTH-1];
            cout     <= base_cout;
            overflow <= base_ovf;
          end else if (accept && early) begin
            out      <= early_res;
            zero     <= (early_res == '0);
            sign     <= early_res[WIDTH-1];
            cout     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            out      <= m_res;
            zero     <= (m_res == '0);
            sign     <= m_res[WIDTH-1];
            cout     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table through a scoreboard queue, plus reset-abort
// and output-backpressure sequences.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]   op;
  logic [W-1:0] src1, src2, out;
  logic         zero, sign, cout, overflow, busy;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .sign(sign), .cout(cout), .overflow(overflow),
    .busy(busy)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;   // {zero, sign, cout, overflow}
    int           lat;
  } exp_t;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  vec_t vt[26];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic [3:0] f, input int l);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.e.res = r; v.e.flg = f; v.e.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   n;
    int   stall_bad;
    exp_t got;
    @(negedge clk);
    in_valid = 1'b1; op = v.op; src1 = v.a; src2 = v.b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    sb.push_back(v.e);
    #1;
    in_valid = 1'b0; op = 5'(($urandom)); src1 = $urandom; src2 = $urandom;
    n = 1;
    stall_bad = 0;
    while (!out_valid && n < 200) begin
      if (in_ready || !busy) stall_bad++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      chk({tag, " out"}, 64'(out), 64'(got.res));
      chk({tag, " flags"}, 64'({zero, sign, cout, overflow}), 64'(got.flg));
      chk({tag, " latency"}, 64'(n), 64'(got.lat));
      if (got.lat > 1) chk({tag, " ready_low_in_busy"}, 64'(stall_bad), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    exp_t e42;

    vt[0]  = mk(5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1);
    vt[1]  = mk(5'h01, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0110, 1);
    vt[2]  = mk(5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1);
    vt[3]  = mk(5'h09, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b0100, 1);
    vt[4]  = mk(5'h05, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1);
    vt[5]  = mk(5'h06, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000, 1);
    vt[6]  = mk(5'h02, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 1);
    vt[7]  = mk(5'h03, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1);
    vt[8]  = mk(5'h04, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b1000, 1);
    vt[9]  = mk(5'h07, 32'h00000001, 32'h00000024, 32'h00000010, 4'b0000, 1);
    vt[10] = mk(5'h08, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 1);
    vt[11] = mk(5'h0C, 32'h00000005, 32'h00000006, 32'h00000000, 4'b1000, 1);
    vt[12] = mk(5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 33);
    vt[13] = mk(5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 33);
    vt[14] = mk(5'h10, 32'h00000006, 32'h00000007, 32'h0000002A, 4'b0000, 33);
    vt[15] = mk(5'h12, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 4'b0100, 33);
    vt[16] = mk(5'h14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0100, 33);
    vt[17] = mk(5'h16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b0100, 33);
    vt[18] = mk(5'h15, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 1);
    vt[19] = mk(5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100, 1);
    vt[20] = mk(5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 1);
    vt[21] = mk(5'h17, 32'h00000064, 32'h00000007, 32'h00000002, 4'b0000, 33);
    vt[22] = mk(5'h17, 32'h00000005, 32'h00000000, 32'h00000005, 4'b0000, 1);
    vt[23] = mk(5'h15, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 4'b0000, 33);
    vt[24] = mk(5'h10, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 4'b0100, 33);
    vt[25] = mk(5'h01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset out", 64'(out), 64'd0);
    chk("reset flags", 64'({zero, sign, cout, overflow}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) run_op(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    in_valid = 1'b1; op = 5'h10; src1 = 32'd3; src2 = 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midmul busy", 64'(busy), 64'd1);
    chk("midmul in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort out", 64'(out), 64'd0);
    chk("abort flags", 64'({zero, sign, cout, overflow}), 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("abort no_result", 64'(n), 64'd0);

    // Backpressure: result held while out_ready is low, new input ignored
    e42.res = 32'd42; e42.flg = 4'b0000; e42.lat = 33;
    @(negedge clk);
    in_valid = 1'b1; op = 5'h10; src1 = 32'd6; src2 = 32'd7;
    @(posedge clk);
    sb.push_back(e42);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp latency", 64'(n), 64'd33);
    @(negedge clk);
    in_valid = 1'b1; op = 5'h00; src1 = 32'd1; src2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp out c%0d", i), 64'(out), 64'(sb[0].res));
      chk($sformatf("bp out_valid c%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp in_ready c%0d", i), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    void'(sb.pop_front());
    chk("bp drained out_valid", 64'(out_valid), 64'd0);
    chk("bp drained in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("bp stall input ignored", 64'(out_valid), 64'd0);
    chk("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle 4-bit-opcode ALU. Executes the ten base integer ops with registered results, and adds RV32M-style multiply/divide/remainder ops on iterative shift-add and restoring-divide datapaths. It sits between decode and writeback in the multi-cycle core. Uses valid/ready on both sides, so the control FSM stalls on `in_ready`/`out_valid`.

Parameters:
WIDTH, 32, operand/result width; must be ≥8 and a power of 2.
SHW, $clog2(WIDTH), shift-amount width (localparam, derived).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operands/op presented.
in_ready  output  1  block can accept; high only in IDLE.
op  input  5  op[4]=0: base op, same encoding as the 4-bit ALU code in op[3:0]; op[4]=1: M op, op[2:0] = RV funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
src1  input  WIDTH  operand A (rs1).
src2  input  WIDTH  operand B (rs2 / shift amount in src2[SHW-1:0]).
out_valid  output  1  result registered and stable.
out_ready  input  1  consumer takes result.
out  output  WIDTH  result.
zero  output  1  out == 0.
sign  output  1  out[WIDTH-1].
cout  output  1  carry/borrow-out for ADD/SUB, else 0.
overflow  output  1  signed overflow for ADD/SUB, else 0.
busy  output  1  state == BUSY.

Behaviour:
- Reset: state=IDLE; out, zero, sign, cout, overflow = 0; out_valid=0; in_ready=1; busy=0. Reset mid-operation aborts; no result is produced.
- Accept: the transfer occurs on the clk edge where in_valid && in_ready. op, src1 and src2 are captured; inputs are ignored at all other times.
- FSM states:
  - IDLE → DONE on accept of a base op or an M-op early-out.
  - IDLE → BUSY on accept of any other M op.
  - BUSY → DONE when the iteration counter reaches WIDTH-1.
  - DONE → IDLE when out_ready.
- out_valid = (state == DONE). out and all flags are held constant while out_valid && !out_ready.
- Base ops (op[4]=0), results valid the cycle after accept (latency 1):
  - 0 ADD, 1 SUB: WIDTH+1-bit arithmetic. For SUB, cout = bit WIDTH of the zero-extended difference, i.e. 1 on borrow.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLTU: result is 1 or 0.
  - 7 SLL, 8 SRL, 9 SRA: shift by src2[SHW-1:0].
  - Codes 10–15: out = 0, flags computed normally.
- Overflow for ADD: operand signs equal and result sign differs. For SUB: operand signs differ and result sign differs from src1.
- zero and sign are always derived from the final registered out, for every op.
- MUL family: radix-2 shift-add over the operand magnitudes. Occupies WIDTH cycles in BUSY, so out_valid rises WIDTH+1 cycles after accept.
  - A 2·WIDTH product is formed and negated at the end if the result sign is negative.
  - Sign of each operand: MULH signs both, MULHSU signs src1 only, MULHU signs neither.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- DIV family: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles in BUSY.
  - Quotient sign = sign(src1) XOR sign(src2); remainder sign = sign(src1). Signed handling applies only to DIV/REM.
- Early-outs skip BUSY, so latency is 1:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give src1.
  - Signed overflow (src1 = most-negative, src2 = −1): DIV gives src1; REM gives 0.
- For M ops, cout = overflow = 0.
- Back-to-back: a new op can be accepted the cycle after out_ready is seen in DONE. There is no accept in the same cycle as output drain, so max throughput for base ops is one result per 2 cycles.

Test Plan:
- Reset/idle: assert rst for 2 cycles mid-MUL → next cycle out_valid=0, in_ready=1, out=0, all flags 0, busy=0.
- ADD overflow: op=0, src1=0x7FFFFFFF, src2=1 → 1 cycle later out=0x80000000, overflow=1, sign=1, cout=0. Then SUB 0−1 → out=0xFFFFFFFF, cout=1.
- SRA/SLT: op=9, src1=0x80000000, src2=0x1F → out=0xFFFFFFFF. Then op=5, src1=0xFFFFFFFF, src2=1 → out=1.
- MULH/MULHU: op=0x11, src1=src2=0xFFFFFFFF → out=0 after exactly 33 cycles. Then op=0x13 on the same operands → out=0xFFFFFFFE. Check in_ready=0 throughout BUSY.
- DIV corner: op=0x14, src1=−7, src2=2 → out=0xFFFFFFFD (−3). Then op=0x16 on the same operands → out=0xFFFFFFFF (−1). Then DIVU x/0 with src1=5 → out=0xFFFFFFFF with latency 1. Then DIV 0x80000000/−1 → out=0x80000000.
- Backpressure: complete MUL 6×7 with out_ready=0 for 5 cycles → out=42 held stable with out_valid=1 and in_ready=0. A new in_valid during the stall is ignored, and the result drains on out_ready.
